// File: rtl/eth_rx_ctrl.sv
// RMII receive frame controller: preamble/SFD detection, header capture, MAC filtering,
// CRC sequencing and FCS-stripped payload forwarding with a per-frame good/bad verdict.
module eth_rx_ctrl #(
  parameter logic [47:0] MAC_ADDR     = 48'h69_69_5A_06_54_91,
  parameter int          PREAMBLE_MIN = 8,
  parameter bit          PROMISC      = 1'b0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        crsdv_in,
  input  logic [1:0]  rxd_in,
  input  logic        crc_ok_in,
  output logic        crc_rst_out,
  output logic        crc_en_out,
  output logic        axiov_out,
  output logic [1:0]  axiod_out,
  output logic [47:0] dst_out,
  output logic [47:0] src_out,
  output logic [15:0] etype_out,
  output logic        done_out,
  output logic        good_out,
  output logic [15:0] good_count_out
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, DEST, SOURCE, ETYPE, PAYLOAD, DONE, DROP} state_t;

  localparam logic [5:0] PRE_MIN = 6'(PREAMBLE_MIN);

  state_t      state;
  logic [5:0]  pcnt;
  logic [4:0]  dcnt;
  logic [5:0]  byte_asm;
  logic [39:0] field_sr;
  logic [31:0] line;
  logic [4:0]  occ;
  logic [11:0] n;
  logic        runt;

  logic [47:0] field_full;
  logic        sfd_hit;
  logic        dst_match;
  logic        verdict;

  // The dibit arriving now completes the current byte; earlier bytes sit in field_sr.
  assign field_full = {field_sr, rxd_in, byte_asm};
  assign dst_match  = PROMISC || (field_full == MAC_ADDR) || (field_full == 48'hFFFF_FFFF_FFFF);
  assign sfd_hit    = (state == PREAMBLE) && crsdv_in && (rxd_in == 2'b11) && (pcnt >= PRE_MIN);
  assign verdict    = crc_ok_in && !runt && (n >= 12'd16) && (n[1:0] == 2'b00);

  assign crc_rst_out = sfd_hit;
  assign crc_en_out  = crsdv_in && (state inside {DEST, SOURCE, ETYPE, PAYLOAD});

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= IDLE;
      pcnt           <= '0;
      dcnt           <= '0;
      byte_asm       <= '0;
      field_sr       <= '0;
      line           <= '0;
      occ            <= '0;
      n              <= '0;
      runt           <= 1'b0;
      axiov_out      <= 1'b0;
      axiod_out      <= '0;
      dst_out        <= '0;
      src_out        <= '0;
      etype_out      <= '0;
      done_out       <= 1'b0;
      good_out       <= 1'b0;
      good_count_out <= '0;
    end else begin
      axiov_out <= 1'b0;
      done_out  <= 1'b0;
      good_out  <= 1'b0;
      case (state)
        IDLE: begin
          if (crsdv_in && rxd_in == 2'b01) begin
            state <= PREAMBLE;
            pcnt  <= 6'd1;
          end
        end
        PREAMBLE: begin
          if (!crsdv_in) begin
            state <= IDLE;
          end else if (rxd_in == 2'b01) begin
            if (pcnt != 6'd63) pcnt <= pcnt + 6'd1;
          end else if (sfd_hit) begin
            state <= DEST;
            dcnt  <= '0;
            occ   <= '0;
            n     <= '0;
            runt  <= 1'b0;
          end else begin
            state <= DROP;
          end
        end
        DEST, SOURCE, ETYPE: begin
          if (!crsdv_in) begin
            state <= DONE;
            runt  <= 1'b1;
          end else begin
            byte_asm <= {rxd_in, byte_asm[5:2]};
            if (dcnt[1:0] == 2'd3) field_sr <= field_full[39:0];
            dcnt <= dcnt + 5'd1;
            if (state == DEST && dcnt == 5'd23) begin
              dst_out <= field_full;
              dcnt    <= '0;
              state   <= dst_match ? SOURCE : DROP;
            end else if (state == SOURCE && dcnt == 5'd23) begin
              src_out <= field_full;
              dcnt    <= '0;
              state   <= ETYPE;
            end else if (state == ETYPE && dcnt == 5'd7) begin
              etype_out <= field_full[15:0];
              dcnt      <= '0;
              state     <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (!crsdv_in) begin
            state <= DONE;
          end else begin
            // The last 16 dibits held at frame end are the FCS and never leave the line.
            line <= {line[29:0], rxd_in};
            if (occ == 5'd16) begin
              axiod_out <= line[31:30];
              axiov_out <= 1'b1;
            end else begin
              occ <= occ + 5'd1;
            end
            if (n != 12'hFFF) n <= n + 12'd1;
          end
        end
        DONE: begin
          done_out <= 1'b1;
          good_out <= verdict;
          if (verdict) good_count_out <= good_count_out + 16'd1;
          state <= IDLE;
        end
        DROP: begin
          if (!crsdv_in) state <= IDLE;
        end
      endcase
    end
  end

endmodule
